sync_fifo_reader: RTL and testbench

- Read-side controller for the team's register-based synchronous FIFO.
- Watches the FIFO occupancy count and generates the raw `rd` strobe, never reading an empty FIFO.
- Absorbs the FIFO's 1-cycle read-data latency (`rd_dat` / `rd_dat_vld`) in a 2-entry output buffer and presents a valid/ready stream downstream.
- Has an optional burst mode that waits for N words, then drains exactly N.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/stream_obuf.sv | 81 ++++++++
 rtl/sync_fifo_reader.sv | 147 ++++++++++++++
 tb/tb_sync_fifo_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Purpose  : shared types for the FIFO read-side controller (FSM states, output buffer depth).
// Latency  : n/a (types and constants only).
// Backpres.: n/a.
package sync_fifo_pkg;

    // Reader FSM states.
    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_FILL,
        BURST,
        DRAIN
    } state_t;

    // Entries in the read-data absorbing buffer. Two entries cover the one
    // outstanding read plus the word currently presented downstream.
    localparam int OBUF_DEEP = 2;

endpackage

// File: rtl/stream_obuf.sv
// Purpose  : 2-entry output buffer absorbing FIFO read data; head entry drives the stream directly.
// Latency  : push at edge t -> visible on o_head / o_count after that edge.
// Backpres.: never stalls push; a push into a full buffer with no pop is dropped and o_ovf sticks.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_push, i_push_dat      write strobe and data
//   i_pop                   remove head entry (ignored when empty)
//   o_count                 occupancy 0..2
//   o_head                  head entry, registered
//   o_ovf                   sticky overflow flag
module stream_obuf
    import sync_fifo_pkg::*;
#(
    parameter int BITWID = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [BITWID-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic [BITWID-1:0] o_head,
    output logic              o_ovf
);

    localparam logic [1:0] CNT_FULL = 2'(OBUF_DEEP);

    logic [BITWID-1:0] r_head;
    logic [BITWID-1:0] r_second;
    logic [1:0]        r_count;
    logic              r_ovf;
    logic              w_pop;

    // A pop on an empty buffer has nothing to remove.
    assign w_pop = i_pop && (r_count != 2'd0);

    // Head/second shift structure keeps the stream data a plain register
    // rather than a read-pointer mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_second <= '0;
            r_count  <= 2'd0;
            r_ovf    <= 1'b0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_push_dat;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_second <= i_push_dat;
                        r_count  <= CNT_FULL;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
                2'b01: begin
                    r_head  <= r_second;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; only the stored words move.
                    if (r_count == 2'd1) begin
                        r_head <= i_push_dat;
                    end else begin
                        r_head   <= r_second;
                        r_second <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/sync_fifo_reader.sv
// Purpose  : read-side controller for the register FIFO: issues fifo_rd, buffers read data, streams it out.
// Latency  : fifo_rd at cycle t -> fifo_rd_dat_vld at t+1 -> out_vld at t+2; 1 word/cycle sustained.
// Backpres.: out_rdy low stops new reads once buffer count plus the outstanding read reaches 2.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset (shared with the FIFO)
//   fifo_num                    FIFO occupancy
//   fifo_rd                     read strobe to FIFO
//   fifo_rd_dat, fifo_rd_dat_vld FIFO read data, valid one cycle after fifo_rd
//   out_dat, out_vld, out_rdy   downstream valid/ready stream
//   cfg_burst_en, cfg_burst_len burst mode select and length (sampled in IDLE)
//   burst_done                  pulse when the last word of a burst pops
//   ovf_err                     sticky: read data arrived with the buffer full
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int DEEPWID = 3,
    parameter int DEEP    = 8,
    parameter int BITWID  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DEEPWID:0]   fifo_num,
    output logic               fifo_rd,
    input  logic [BITWID-1:0]  fifo_rd_dat,
    input  logic               fifo_rd_dat_vld,
    output logic [BITWID-1:0]  out_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    input  logic               cfg_burst_en,
    input  logic [DEEPWID:0]   cfg_burst_len,
    output logic               burst_done,
    output logic               ovf_err
);

    localparam logic [DEEPWID:0] LEN_MAX = (DEEPWID+1)'(DEEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_inflight;
    logic [DEEPWID:0] r_len;
    logic [DEEPWID:0] r_issued;
    logic [DEEPWID:0] r_delivered;
    logic             r_from_burst;

    logic [1:0]       w_count;
    logic             w_pop;
    logic [2:0]       w_credit_sum;
    logic             w_credit_ok;
    logic             w_permit;
    logic [DEEPWID:0] w_len_clamped;
    logic [DEEPWID:0] w_delivered_inc;

    stream_obuf #(
        .BITWID (BITWID)
    ) u_obuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (fifo_rd_dat_vld),
        .i_push_dat (fifo_rd_dat),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_head     (out_dat),
        .o_ovf      (ovf_err)
    );

    assign out_vld = (w_count != 2'd0);
    assign w_pop   = out_vld && out_rdy;

    // Words that will occupy the buffer after this cycle if no new read is
    // issued. pop implies count >= 1, so the sum never underflows.
    assign w_credit_sum = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit_ok  = (w_credit_sum < 3'd2);

    // cfg_burst_en is deliberately kept out of this path: a read issued in
    // the cycle burst mode is requested simply drains through DRAIN.
    always_comb begin
        w_permit = 1'b0;
        case (r_state)
            STREAM:  w_permit = 1'b1;
            BURST:   w_permit = (r_issued < r_len);
            default: w_permit = 1'b0;
        endcase
    end

    assign fifo_rd = w_credit_ok && (fifo_num != '0) && w_permit;

    always_comb begin
        w_len_clamped = cfg_burst_len;
        if (cfg_burst_len == '0) begin
            w_len_clamped = (DEEPWID+1)'(1);
        end else if (cfg_burst_len > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end
    end

    assign w_delivered_inc = r_delivered + (DEEPWID+1)'(1);
    assign burst_done      = w_pop && r_from_burst && (w_delivered_inc == r_len);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      w_state_nxt = cfg_burst_en ? WAIT_FILL : STREAM;
            STREAM:    if (cfg_burst_en) w_state_nxt = DRAIN;
            WAIT_FILL: if (fifo_num >= r_len) w_state_nxt = BURST;
            BURST:     if (r_issued == r_len) w_state_nxt = DRAIN;
            DRAIN:     if ((w_count == 2'd0) && !r_inflight) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_inflight   <= 1'b0;
            r_len        <= (DEEPWID+1)'(1);
            r_issued     <= '0;
            r_delivered  <= '0;
            r_from_burst <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd;
            case (r_state)
                IDLE: begin
                    // Buffer is empty here, so the counters start clean
                    // for whichever mode follows.
                    r_issued     <= '0;
                    r_delivered  <= '0;
                    r_from_burst <= cfg_burst_en;
                    if (cfg_burst_en) begin
                        r_len <= w_len_clamped;
                    end
                end
                BURST, DRAIN: begin
                    if (fifo_rd) begin
                        r_issued <= r_issued + (DEEPWID+1)'(1);
                    end
                    if (w_pop && r_from_burst) begin
                        r_delivered <= w_delivered_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
module tb_sync_fifo_reader;

    localparam int DEEPWID = 3;
    localparam int DEEP    = 8;
    localparam int BITWID  = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DEEPWID:0]   fifo_num;
    logic               fifo_rd;
    logic [BITWID-1:0]  fifo_rd_dat;
    logic               fifo_rd_dat_vld;
    logic [BITWID-1:0]  out_dat;
    logic               out_vld;
    logic               out_rdy = 1'b0;
    logic               cfg_burst_en = 1'b0;
    logic [DEEPWID:0]   cfg_burst_len = '0;
    logic               burst_done;
    logic               ovf_err;

    always #5 clk = ~clk;

    sync_fifo_reader #(.DEEPWID(DEEPWID), .DEEP(DEEP), .BITWID(BITWID)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_num        (fifo_num),
        .fifo_rd         (fifo_rd),
        .fifo_rd_dat     (fifo_rd_dat),
        .fifo_rd_dat_vld (fifo_rd_dat_vld),
        .out_dat         (out_dat),
        .out_vld         (out_vld),
        .out_rdy         (out_rdy),
        .cfg_burst_en    (cfg_burst_en),
        .cfg_burst_len   (cfg_burst_len),
        .burst_done      (burst_done),
        .ovf_err         (ovf_err)
    );

    // Register FIFO environment: 1-cycle read latency, shares rst_n.
    logic [BITWID-1:0] mem [DEEP];
    logic [DEEPWID:0]  wp, rp;
    logic              wr_en = 1'b0;
    logic [BITWID-1:0] wr_dat = '0;

    assign fifo_num = wp - rp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; fifo_rd_dat <= '0; fifo_rd_dat_vld <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wp[DEEPWID-1:0]] <= wr_dat;
                wp <= wp + 1'b1;
            end
            fifo_rd_dat_vld <= fifo_rd;
            if (fifo_rd) begin
                fifo_rd_dat <= mem[rp[DEEPWID-1:0]];
                rp <= rp + 1'b1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference model: every word written leaves the stream in write order;
    // in burst mode every L-th delivered word carries burst_done.
    logic [BITWID-1:0] sb [$];
    int bd_L = 0, bd_cnt = 0;

    int cyc = 0;
    int rd_total, rd_run, rd_run_max, pop_total, pop_run, pop_run_max, bd_total;
    int first_rd, first_vld;

    task automatic clr_stats();
        rd_total = 0; rd_run = 0; rd_run_max = 0;
        pop_total = 0; pop_run = 0; pop_run_max = 0;
        bd_total = 0; first_rd = -1; first_vld = -1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_empty_rd", 32'(fifo_rd && (fifo_num == '0)), 0);
            chk("ovf", 32'(ovf_err), 0);
            if (fifo_rd) begin
                rd_total++; rd_run++;
                if (first_rd < 0) first_rd = cyc;
            end else begin
                rd_run = 0;
            end
            if (rd_run > rd_run_max) rd_run_max = rd_run;
            if (out_vld && first_vld < 0) first_vld = cyc;
            if (out_vld && out_rdy) begin
                pop_total++; pop_run++;
                chk("pop_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("dat", 32'(out_dat), 32'(sb.pop_front()));
                if (bd_L != 0) begin
                    bd_cnt++;
                    chk("bdone_at_pop", 32'(burst_done), 32'(bd_cnt % bd_L == 0));
                end else begin
                    chk("bdone_stream", 32'(burst_done), 0);
                end
            end else begin
                pop_run = 0;
                chk("bdone_nopop", 32'(burst_done), 0);
            end
            if (pop_run > pop_run_max) pop_run_max = pop_run;
            if (burst_done) bd_total++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [BITWID-1:0] d);
        wr_en = 1'b1; wr_dat = d; sb.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input logic ben, input logic [DEEPWID:0] len);
        rst_n = 1'b0; wr_en = 1'b0;
        sb.delete(); bd_L = 0; bd_cnt = 0;
        cfg_burst_en = ben; cfg_burst_len = len;
        step(2);
        chk("rst_rd",    32'(fifo_rd), 0);
        chk("rst_vld",   32'(out_vld), 0);
        chk("rst_dat",   32'(out_dat), 0);
        chk("rst_bdone", 32'(burst_done), 0);
        chk("rst_ovf",   32'(ovf_err), 0);
        rst_n = 1'b1;
        step();
        clr_stats();
    endtask

    task automatic wait_rd(input int n, input int budget);
        int k = 0;
        while (rd_total < n && k < budget) begin
            step();
            k++;
        end
        if (rd_total < n) chk("rd_timeout", 32'(rd_total), 32'(n));
    endtask

    initial begin
        int written, lc;
        logic [DEEPWID:0] len;

        // Streaming, full throughput.
        do_reset(1'b0, '0);
        out_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) wr(BITWID'(i));
        step(6);
        chk("s_rd_cnt",  32'(rd_total), 8);
        chk("s_rd_run",  32'(rd_run_max), 8);
        chk("s_latency", 32'(first_vld - first_rd), 2);
        chk("s_pops",    32'(pop_total), 8);
        chk("s_pop_run", 32'(pop_run_max), 8);
        chk("s_num",     32'(fifo_num), 0);

        // Backpressure: only two reads fit the buffer.
        clr_stats();
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) wr(BITWID'(5'h09 + i));
        step(4);
        chk("bp_rd_cnt", 32'(rd_total), 2);
        chk("bp_num",    32'(fifo_num), 4);
        chk("bp_vld",    32'(out_vld), 1);
        clr_stats();
        out_rdy = 1'b1;
        step(10);
        chk("bp_pops",    32'(pop_total), 6);
        chk("bp_pop_run", 32'(pop_run_max), 6);
        chk("bp_num_end", 32'(fifo_num), 0);

        // Burst of 4: nothing read until the 4th word lands.
        do_reset(1'b1, 4'd4);
        bd_L = 4;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) wr(BITWID'(5'h11 + i));
        step(5);
        chk("b4_hold", 32'(rd_total), 0);
        wr(5'h14);
        step(12);
        chk("b4_rd",   32'(rd_total), 4);
        chk("b4_pops", 32'(pop_total), 4);
        chk("b4_bd",   32'(bd_total), 1);
        for (int i = 0; i < 4; i++) wr(BITWID'(5'h15 + i));
        step(12);
        chk("b4_rd2", 32'(rd_total), 8);
        chk("b4_bd2", 32'(bd_total), 2);

        // Length 0 behaves as 1.
        do_reset(1'b1, 4'd0);
        bd_L = 1;
        out_rdy = 1'b1;
        wr(5'h1a);
        step(8);
        chk("b0_rd", 32'(rd_total), 1);
        chk("b0_bd", 32'(bd_total), 1);
        wr(5'h1b);
        step(8);
        chk("b0_rd2", 32'(rd_total), 2);
        chk("b0_bd2", 32'(bd_total), 2);

        // Length 15 clamps to DEEP.
        do_reset(1'b1, 4'd15);
        bd_L = DEEP;
        out_rdy = 1'b1;
        for (int i = 0; i < 7; i++) wr(BITWID'(i + 2));
        step(5);
        chk("b15_hold", 32'(rd_total), 0);
        wr(5'h1f);
        step(16);
        chk("b15_rd",   32'(rd_total), 8);
        chk("b15_pops", 32'(pop_total), 8);
        chk("b15_bd",   32'(bd_total), 1);

        // Reset in the middle of a burst.
        do_reset(1'b1, 4'd4);
        bd_L = 4;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(BITWID'(5'h03 + i));
        wait_rd(2, 20);
        step(3);
        chk("mr_rd",  32'(rd_total), 2);
        chk("mr_vld", 32'(out_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_rd",    32'(fifo_rd), 0);
        chk("mr_async_vld",   32'(out_vld), 0);
        chk("mr_async_dat",   32'(out_dat), 0);
        chk("mr_async_bdone", 32'(burst_done), 0);
        chk("mr_async_ovf",   32'(ovf_err), 0);
        do_reset(1'b0, '0);
        out_rdy = 1'b1;
        wr(5'h0c);
        wr(5'h0d);
        step(6);
        chk("mr_pops", 32'(pop_total), 2);

        // Switch STREAM -> burst with words in flight.
        clr_stats();
        for (int i = 0; i < 3; i++) wr(BITWID'(5'h16 + i));
        wait_rd(3, 10);
        cfg_burst_en = 1'b1;
        cfg_burst_len = 4'd2;
        step(8);
        chk("ms_pops", 32'(pop_total), 3);
        chk("ms_bd",   32'(bd_total), 0);
        bd_L = 2; bd_cnt = 0;
        clr_stats();
        wr(5'h01);
        wr(5'h02);
        step(10);
        chk("ms_rd2", 32'(rd_total), 2);
        chk("ms_bd2", 32'(bd_total), 1);

        // Randomized streaming.
        do_reset(1'b0, '0);
        repeat (400) begin
            out_rdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 6 && fifo_num < DEEP) wr(BITWID'($urandom));
            else step();
        end
        out_rdy = 1'b1;
        step(20);
        chk("rs_left", 32'(sb.size()), 0);
        chk("rs_num",  32'(fifo_num), 0);

        // Randomized bursts with random lengths.
        for (int r = 0; r < 4; r++) begin
            len = DEEPWID'(0) | (DEEPWID+1)'($urandom_range(0, 15));
            lc  = (len == 0) ? 1 : ((int'(len) > DEEP) ? DEEP : int'(len));
            do_reset(1'b1, len);
            bd_L = lc; bd_cnt = 0;
            written = 0;
            repeat (150) begin
                out_rdy = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 5 && fifo_num < DEEP) begin
                    wr(BITWID'($urandom));
                    written++;
                end else begin
                    step();
                end
            end
            out_rdy = 1'b1;
            step(100);
            chk("rb_left", 32'(sb.size()), 32'(written % lc));
            chk("rb_num",  32'(fifo_num), 32'(written % lc));
            chk("rb_bd",   32'(bd_total), 32'(written / lc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
